alu_tmr_voter: RTL

Parametrised majority voter and fault monitor for N replicated ALU result channels (result word, compare flag, ready) exported from the core for fault-injection campaigns. Sits in the testbench subsystem beside the core, samples the replicated ALU outputs on a strobe, and produces one registered voted result. Per channel it also keeps error counters, consecutive-disagreement tracking with sticky "faulty" marking, and a capture of the first divergence event. Generalises the fixed three-channel export to NUM_CH channels of configurable width.

---
 rtl/alu_tmr_voter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_tmr_voter.sv
// Majority voter and per-channel fault monitor for NUM_CH replicated ALU result channels.
// One register stage from valid_i to voted/mismatch outputs and statistics; no backpressure.
module alu_tmr_voter #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int THRESH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   result_i,
    input  logic [NUM_CH-1:0]          cmp_i,
    input  logic [NUM_CH-1:0]          ready_i,
    input  logic                       clear_i,
    output logic                       voted_valid_o,
    output logic [DATA_W-1:0]          voted_result_o,
    output logic                       voted_cmp_o,
    output logic                       voted_ready_o,
    output logic                       no_majority_o,
    output logic [NUM_CH-1:0]          mismatch_o,
    output logic [NUM_CH-1:0]          faulty_o,
    output logic [NUM_CH*CNT_W-1:0]    err_cnt_o,
    output logic                       first_valid_o,
    output logic [NUM_CH-1:0]          first_mask_o,
    output logic [CNT_W-1:0]           first_sample_o
);
    localparam int              TW   = DATA_W + 2;
    localparam int              AW   = $clog2(NUM_CH + 1);
    localparam logic [AW-1:0]   MAJ  = AW'(NUM_CH / 2 + 1);
    localparam logic [3:0]      TH   = 4'(THRESH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [TW-1:0]     tup [NUM_CH];
    logic [NUM_CH-1:0] flt_eff, mism;
    logic              found;
    logic [TW-1:0]     vote;
    logic [AW-1:0]     agree;

    logic [CNT_W-1:0]  err_q [NUM_CH];
    logic [CNT_W-1:0]  err_d [NUM_CH];
    logic [3:0]        consec_q [NUM_CH];
    logic [3:0]        consec_d [NUM_CH];
    logic [NUM_CH-1:0] faulty_q, faulty_d;
    logic [CNT_W-1:0]  samp_q, samp_d;
    logic              first_vld_q, first_vld_d;
    logic [NUM_CH-1:0] first_mask_q, first_mask_d;
    logic [CNT_W-1:0]  first_samp_q, first_samp_d;

    logic              vv_q, nm_q, vcmp_q, vrdy_q;
    logic [DATA_W-1:0] vres_q;
    logic [NUM_CH-1:0] mm_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign tup[g] = {result_i[g*DATA_W +: DATA_W], cmp_i[g], ready_i[g]};
        assign err_cnt_o[g*CNT_W +: CNT_W] = err_q[g];
    end

    // A coincident clear takes effect before the vote, so previously faulty channels vote again.
    always_comb begin
        flt_eff = clear_i ? '0 : faulty_q;
        found   = 1'b0;
        vote    = '0;
        agree   = '0;
        mism    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            agree = '0;
            for (int j = 0; j < NUM_CH; j++) begin
                if (!flt_eff[j] && tup[j] == tup[c]) agree = agree + AW'(1);
            end
            if (!found && !flt_eff[c] && agree >= MAJ) begin
                found = 1'b1;
                vote  = tup[c];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            mism[c] = !flt_eff[c] && (!found || tup[c] != vote);
        end
    end

    always_comb begin
        samp_d       = clear_i ? '0 : samp_q;
        first_vld_d  = clear_i ? 1'b0 : first_vld_q;
        first_mask_d = clear_i ? '0 : first_mask_q;
        first_samp_d = clear_i ? '0 : first_samp_q;
        faulty_d     = flt_eff;
        for (int c = 0; c < NUM_CH; c++) begin
            err_d[c]    = clear_i ? '0 : err_q[c];
            consec_d[c] = clear_i ? '0 : consec_q[c];
        end
        if (valid_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (mism[c]) begin
                    if (err_d[c] != CMAX)     err_d[c]    = err_d[c] + 1'b1;
                    if (consec_d[c] != 4'hF)  consec_d[c] = consec_d[c] + 4'd1;
                    if (consec_d[c] >= TH)    faulty_d[c] = 1'b1;
                end else begin
                    consec_d[c] = '0;
                end
            end
            if (!first_vld_d && (|mism || !found)) begin
                first_vld_d  = 1'b1;
                first_mask_d = mism;
                first_samp_d = samp_d;
            end
            if (samp_d != CMAX) samp_d = samp_d + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vv_q         <= 1'b0;
            nm_q         <= 1'b0;
            mm_q         <= '0;
            vres_q       <= '0;
            vcmp_q       <= 1'b0;
            vrdy_q       <= 1'b0;
            faulty_q     <= '0;
            samp_q       <= '0;
            first_vld_q  <= 1'b0;
            first_mask_q <= '0;
            first_samp_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                err_q[c]    <= '0;
                consec_q[c] <= '0;
            end
        end else begin
            vv_q <= valid_i;
            nm_q <= valid_i && !found;
            mm_q <= valid_i ? mism : '0;
            if (valid_i) {vres_q, vcmp_q, vrdy_q} <= vote;
            faulty_q     <= faulty_d;
            samp_q       <= samp_d;
            first_vld_q  <= first_vld_d;
            first_mask_q <= first_mask_d;
            first_samp_q <= first_samp_d;
            for (int c = 0; c < NUM_CH; c++) begin
                err_q[c]    <= err_d[c];
                consec_q[c] <= consec_d[c];
            end
        end
    end

    assign voted_valid_o  = vv_q;
    assign voted_result_o = vres_q;
    assign voted_cmp_o    = vcmp_q;
    assign voted_ready_o  = vrdy_q;
    assign no_majority_o  = nm_q;
    assign mismatch_o     = mm_q;
    assign faulty_o       = faulty_q;
    assign first_valid_o  = first_vld_q;
    assign first_mask_o   = first_mask_q;
    assign first_sample_o = first_samp_q;
endmodule
